// File: rtl/vector_load_pkg.sv
// Shared definitions for the vector loader and its sequencer.
// Holds the sequencer state encoding and the small elaboration-time helpers
// (clog2, zero-to-one clamp, beats-per-codeword) so every block that talks
// to the loader derives the same beat count and counter widths.
package vector_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // A parallelism of 0 means one symbol per beat, same as in the loader.
    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int beats_per_word(input int word_len, input int parallelism);
        int p;
        p = at_least_one(parallelism);
        return (word_len + p - 1) / p;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int width_of(input int n);
        return at_least_one(clog2(n));
    endfunction

endpackage

// File: rtl/vector_load_beat_counter.sv
// Beat / codeword position counter.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   clr          synchronous clear of both counters
//   en           one beat transferred this cycle
//   beat_cnt     beat index inside the current codeword
//   word_idx     index of the current codeword
//   beat_last    beat_cnt is the last beat of a codeword
//   word_last    word_idx is the last codeword of the run
// On the last beat the beat counter wraps to 0 and the word index advances,
// except on the final codeword where the word index holds so the owner can
// still report which codeword just finished.
module vector_load_beat_counter
    import vector_load_pkg::*;
#(
    parameter int  BEATS    = 1023,
    parameter int  WORD_NUM = 10,
    localparam int BW       = width_of(BEATS),
    localparam int WW       = width_of(WORD_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [BW-1:0] beat_cnt,
    output logic [WW-1:0] word_idx,
    output logic          beat_last,
    output logic          word_last
);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(WORD_NUM - 1);
    localparam logic [BW-1:0] BEAT_ONE  = BW'(1);
    localparam logic [WW-1:0] WORD_ONE  = WW'(1);

    assign beat_last = (beat_cnt == LAST_BEAT);
    assign word_last = (word_idx == LAST_WORD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            word_idx <= '0;
        end else if (clr) begin
            beat_cnt <= '0;
            word_idx <= '0;
        end else if (en) begin
            if (beat_last) begin
                beat_cnt <= '0;
                if (!word_last) word_idx <= word_idx + WORD_ONE;
            end else begin
                beat_cnt <= beat_cnt + BEAT_ONE;
            end
        end
    end

endmodule

// File: rtl/vector_load_sequencer.sv
// Sequencer that drives one vector loader into the BCH decoder datapath.
// Ports:
//   clk, in_Arst       clock, asynchronous active-high reset
//   in_start           start a run (honoured in IDLE or DONE)
//   in_abort           abandon the run, back to IDLE next cycle
//   in_dec_ready       decoder accepts a beat this cycle
//   out_ld_Srst        loader synchronous clear (CLR state)
//   out_ld_en          loader pointer advance
//   out_valid          beat presented to the decoder
//   out_sof, out_eof   first / last beat of a codeword (valid-qualified)
//   out_word_idx       codeword currently streaming
//   out_busy           CLR, STREAM or GAP
//   out_done           run complete (DONE)
//   dbg_state          current FSM state, for observation
// Handshake: a beat moves exactly in a cycle with out_valid=1. In STREAM,
// out_valid follows in_dec_ready in the same cycle because the loader's data
// is combinational from its pointer; out_ld_en equals out_valid so the loader
// pointer and beat counter always step together. in_abort forces out_valid
// low in its cycle.
module vector_load_sequencer
    import vector_load_pkg::*;
#(
    parameter int  WORD_LEN    = 1023,
    parameter int  PARALLELISM = 1,
    parameter int  WORD_NUM    = 10,
    parameter int  GAP_CYCLES  = 0,
    localparam int BEATS       = beats_per_word(WORD_LEN, PARALLELISM),
    localparam int BW          = width_of(BEATS),
    localparam int WW          = width_of(WORD_NUM),
    localparam int GW          = width_of(GAP_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          in_Arst,
    input  logic          in_start,
    input  logic          in_abort,
    input  logic          in_dec_ready,
    output logic          out_ld_Srst,
    output logic          out_ld_en,
    output logic          out_valid,
    output logic          out_sof,
    output logic          out_eof,
    output logic [WW-1:0] out_word_idx,
    output logic          out_busy,
    output logic          out_done,
    output logic [2:0]    dbg_state
);

    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    seq_state_t    state;
    logic [GW-1:0] gap_cnt;
    logic [BW-1:0] beat_cnt;
    logic [WW-1:0] word_idx;
    logic          beat_last;
    logic          word_last;
    logic          xfer;
    logic          cnt_clr;

    assign xfer = (state == ST_STREAM) && in_dec_ready && !in_abort;

    // Counters are also cleared on the DONE->CLR edge so the CLR cycle
    // already reports codeword 0 instead of the previous run's last index.
    assign cnt_clr = in_abort || (state == ST_CLR) || ((state == ST_DONE) && in_start);

    vector_load_beat_counter #(
        .BEATS    (BEATS),
        .WORD_NUM (WORD_NUM)
    ) u_beat_counter (
        .clk       (clk),
        .rst       (in_Arst),
        .clr       (cnt_clr),
        .en        (xfer),
        .beat_cnt  (beat_cnt),
        .word_idx  (word_idx),
        .beat_last (beat_last),
        .word_last (word_last)
    );

    always_ff @(posedge clk or posedge in_Arst) begin
        if (in_Arst) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else if (in_abort) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_start) state <= ST_CLR;
                end
                ST_CLR: begin
                    gap_cnt <= '0;
                    state   <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (xfer && beat_last) begin
                        if (word_last) begin
                            state <= ST_DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state   <= ST_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_ONE;
                    if (gap_cnt == GAP_LAST) state <= ST_STREAM;
                end
                ST_DONE: begin
                    if (in_start) state <= ST_CLR;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_ld_Srst  = (state == ST_CLR);
    assign out_ld_en    = xfer;
    assign out_valid    = xfer;
    assign out_sof      = xfer && (beat_cnt == '0);
    assign out_eof      = xfer && beat_last;
    assign out_word_idx = word_idx;
    assign out_busy     = (state == ST_CLR) || (state == ST_STREAM) || (state == ST_GAP);
    assign out_done     = (state == ST_DONE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Bench for vector_load_sequencer. Three instances share one set of inputs:
//   0: WORD_LEN=7, P=3, WORD_NUM=2, GAP=0
//   1: WORD_LEN=7, P=3, WORD_NUM=2, GAP=2
//   2: WORD_LEN=4, P=4, WORD_NUM=3, GAP=0 (one beat per codeword)
// The reference tracks each run as a count of beats delivered; beat and
// codeword positions come from division/modulo of that count. A bench-side
// loader pointer follows the DUT's clear/enable outputs.
module tb_vector_load_sequencer;
    import vector_load_pkg::*;

    localparam int NI = 3;
    localparam int CFG_WL [NI] = '{7, 7, 4};
    localparam int CFG_P  [NI] = '{3, 3, 4};
    localparam int CFG_N  [NI] = '{2, 2, 3};
    localparam int CFG_G  [NI] = '{0, 2, 0};

    logic clk, rst, start, abort, ready;
    logic [NI-1:0]   o_srst, o_en, o_valid, o_sof, o_eof, o_busy, o_done;
    logic [2*NI-1:0] o_widx;
    logic [3*NI-1:0] o_state;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int WWL = (CFG_N[g] > 1) ? $clog2(CFG_N[g]) : 1;
        logic [WWL-1:0] widx;
        logic [2:0]     st;
        vector_load_sequencer #(
            .WORD_LEN    (CFG_WL[g]),
            .PARALLELISM (CFG_P[g]),
            .WORD_NUM    (CFG_N[g]),
            .GAP_CYCLES  (CFG_G[g])
        ) u_dut (
            .clk          (clk),
            .in_Arst      (rst),
            .in_start     (start),
            .in_abort     (abort),
            .in_dec_ready (ready),
            .out_ld_Srst  (o_srst[g]),
            .out_ld_en    (o_en[g]),
            .out_valid    (o_valid[g]),
            .out_sof      (o_sof[g]),
            .out_eof      (o_eof[g]),
            .out_word_idx (widx),
            .out_busy     (o_busy[g]),
            .out_done     (o_done[g]),
            .dbg_state    (st)
        );
        assign o_widx[2*g +: 2]  = 2'(widx);
        assign o_state[3*g +: 3] = st;
    end

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: phase 0 idle, 1 clear, 2 running (gap when m_gap>0), 3 done
    int m_phase [NI];
    int m_pos   [NI];
    int m_gap   [NI];
    int ld_ptr  [NI];
    bit last_eof[NI];
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    function automatic int nbeats(input int i);
        return (CFG_WL[i] + CFG_P[i] - 1) / CFG_P[i];
    endfunction

    function automatic bit exp_valid(input int i);
        return (m_phase[i] == 2) && (m_gap[i] == 0) && ready && !abort;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_phase[i]  = 0;
            m_pos[i]    = 0;
            m_gap[i]    = 0;
            last_eof[i] = 1'b0;
        end
    endtask

    task automatic enter_clr(input int i);
        m_phase[i] = 1;
        m_pos[i]   = 0;
        m_gap[i]   = 0;
        if (i == 0) begin
            exp_q.delete();
            for (int k = 0; k < CFG_N[0] * nbeats(0); k++) exp_q.push_back(16'(k));
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            int         b;
            int         ew;
            bit         v;
            seq_state_t est;
            logic [15:0] e;
            b = nbeats(i);
            v = exp_valid(i);
            chk("valid",   i, o_valid[i], v);
            chk("ld_en",   i, o_en[i],    v);
            chk("sof",     i, o_sof[i],   v && (m_pos[i] % b == 0));
            chk("eof",     i, o_eof[i],   v && (m_pos[i] % b == b - 1));
            chk("ld_srst", i, o_srst[i],  m_phase[i] == 1);
            chk("busy",    i, o_busy[i],  (m_phase[i] == 1) || (m_phase[i] == 2));
            chk("done",    i, o_done[i],  m_phase[i] == 3);
            ew = (m_phase[i] == 2) ? m_pos[i] / b : (m_phase[i] == 3) ? CFG_N[i] - 1 : 0;
            chk("word_idx", i, o_widx[2*i +: 2], ew);
            case (m_phase[i])
                1:       est = ST_CLR;
                2:       est = (m_gap[i] > 0) ? ST_GAP : ST_STREAM;
                3:       est = ST_DONE;
                default: est = ST_IDLE;
            endcase
            chk("state", i, o_state[3*i +: 3], est);
            if (last_eof[i] && m_phase[i] == 2)
                chk("ld_word_num", i, o_widx[2*i +: 2], ld_ptr[i] / b);
            if (i == 0 && o_valid[0] === 1'b1) begin
                chk("sb_nonempty", 0, exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_beat", 0, ld_ptr[0], e);
                end
            end
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_edge();
        logic [NI-1:0] srst_s, en_s, eofx_s;
        bit v;
        int b;
        srst_s = o_srst;
        en_s   = o_en;
        eofx_s = o_eof & o_valid;
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            b = nbeats(i);
            v = exp_valid(i);
            last_eof[i] = eofx_s[i];
            if (srst_s[i]) ld_ptr[i] = 0;
            else if (en_s[i]) ld_ptr[i]++;
            if (rst || abort) begin
                m_phase[i]  = 0;
                m_pos[i]    = 0;
                m_gap[i]    = 0;
                if (rst) last_eof[i] = 1'b0;
            end else begin
                case (m_phase[i])
                    0: if (start) enter_clr(i);
                    1: begin
                        m_phase[i] = 2;
                        m_pos[i]   = 0;
                        m_gap[i]   = 0;
                    end
                    2: begin
                        if (m_gap[i] > 0) begin
                            m_gap[i]--;
                        end else if (v) begin
                            m_pos[i]++;
                            if (m_pos[i] % b == 0) begin
                                if (m_pos[i] == CFG_N[i] * b) m_phase[i] = 3;
                                else m_gap[i] = CFG_G[i];
                            end
                        end
                    end
                    default: if (start) enter_clr(i);
                endcase
            end
        end
        #1;
    endtask

    initial begin
        int  beats0;
        bit  fin;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        model_reset();
        for (int i = 0; i < NI; i++) ld_ptr[i] = 0;

        // reset state, before any clock edge and across two edges
        #2;
        check_all();
        repeat (2) begin
            tick_check();
            tick_edge();
        end
        rst = 1'b0;

        // nominal run, then a restart from DONE with identical expectations
        for (int run = 0; run < 2; run++) begin
            start = 1'b1;
            ready = 1'b1;
            for (int c = 0; c < 12; c++) begin
                bit first;
                first = (run == 1) && (c == 0);
                tick_check();
                chk("n_srst0",  c, o_srst[0],   c == 1);
                chk("n_valid0", c, o_valid[0],  c >= 2 && c <= 7);
                chk("n_sof0",   c, o_sof[0],    c == 2 || c == 5);
                chk("n_eof0",   c, o_eof[0],    c == 4 || c == 7);
                chk("n_widx0",  c, o_widx[1:0], (c >= 5 || first) ? 1 : 0);
                chk("n_done0",  c, o_done[0],   c >= 8 || first);
                chk("n_valid1", c, o_valid[1],  (c >= 2 && c <= 4) || (c >= 7 && c <= 9));
                chk("n_sof1",   c, o_sof[1],    c == 2 || c == 7);
                chk("n_done1",  c, o_done[1],   c >= 10 || first);
                chk("n_sof2",   c, o_sof[2],    c >= 2 && c <= 4);
                chk("n_eof2",   c, o_eof[2],    c >= 2 && c <= 4);
                chk("n_done2",  c, o_done[2],   c >= 5 || first);
                tick_edge();
                start = 1'b0;
            end
        end

        // backpressure: ready 1,0,0,...
        start  = 1'b1;
        beats0 = 0;
        fin    = 1'b0;
        for (int k = 0; k < 120 && !fin; k++) begin
            ready = ((k % 3) == 0);
            tick_check();
            if (o_valid[0] === 1'b1) beats0++;
            if (k > 0 && (&o_done)) fin = 1'b1;
            tick_edge();
            start = 1'b0;
        end
        chk("bp_finished", 0, fin, 1);
        chk("bp_beats0", 0, beats0, 6);

        // randomized start/abort/ready
        for (int k = 0; k < 400; k++) begin
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 29) == 0);
            ready = ($urandom_range(0, 3) != 0);
            tick_check();
            tick_edge();
        end
        start = 1'b0;

        // abort during beat 2 of codeword 1, then replay
        abort = 1'b1;
        ready = 1'b1;
        tick_check();
        tick_edge();
        abort = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 8; c++) begin
            abort = (c == 6);
            tick_check();
            if (c == 6) chk("ab_valid0", c, o_valid[0], 0);
            if (c == 7) begin
                chk("ab_busy", c, o_busy, 0);
                chk("ab_widx", c, o_widx, 0);
            end
            tick_edge();
            start = 1'b0;
        end
        abort = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick_check();
            if (c == 1) chk("rp_srst", c, o_srst, 3'b111);
            tick_edge();
            start = 1'b0;
        end

        // asynchronous reset while instance 1 sits in its gap
        start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick_check();
            tick_edge();
            start = 1'b0;
        end
        chk("ar_in_gap", 1, o_state[5:3], ST_GAP);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("ar_busy", 0, o_busy, 0);
        tick_check();
        tick_edge();
        #2;
        rst = 1'b0;
        tick_check();
        chk("ar_idle", 1, o_state[5:3], ST_IDLE);
        tick_edge();

        // clean run after reset: loader re-cleared, scoreboard drained
        start = 1'b1;
        ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick_check();
            tick_edge();
            start = 1'b0;
        end
        chk("sb_drained", 0, exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_load_sequencer.md
Name: vector_load_sequencer

Overview:
Controller that sequences one vector_load_hex_module instance so it can feed the BCH decoder datapath in bench and FPGA-emulation builds. It clears the loader, gates its enable with the decoder's ready, and tracks beat and codeword position. It marks the first and last beat of each codeword, inserts optional idle gaps between codewords, and reports completion after WORD_NUM codewords.

Parameters:
WORD_LEN, 1023, codeword length in symbols; must match the loader.
PARALLELISM, 1, symbols per beat; 0 is treated as 1, as in the loader.
WORD_NUM, 10, codewords per run.
GAP_CYCLES, 0, idle cycles inserted between consecutive codewords.
Local: P = max(PARALLELISM,1); BEATS = ceil(WORD_LEN/P); BW = max(1,clog2(BEATS)); WW = max(1,clog2(WORD_NUM)); GW = max(1,clog2(GAP_CYCLES+1)).

Ports:
clk  in  1  system clock, rising edge.
in_Arst  in  1  asynchronous reset, active-high.
in_start  in  1  start-run pulse; sampled in IDLE or DONE.
in_abort  in  1  abandon run; returns to IDLE.
in_dec_ready  in  1  decoder can accept a beat this cycle.
out_ld_Srst  out  1  drives the loader's synchronous clear.
out_ld_en  out  1  drives the loader's in_en.
out_valid  out  1  beat presented to decoder this cycle.
out_sof  out  1  first beat of a codeword (qualified by out_valid).
out_eof  out  1  last beat of a codeword (qualified by out_valid).
out_word_idx  out  WW  index of the codeword currently streaming.
out_busy  out  1  high in CLR, STREAM, GAP.
out_done  out  1  high while in DONE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat_cnt=0, word_idx=0, gap_cnt=0. All 1-bit outputs 0; out_word_idx=0.
- States: IDLE, CLR, STREAM, GAP, DONE. State and counters are registered. Outputs are decoded combinationally from state, counters and in_dec_ready.
- IDLE: in_start -> CLR.
- CLR: lasts exactly 1 cycle. out_ld_Srst=1; beat_cnt, word_idx and gap_cnt are cleared. Next state is STREAM.
- STREAM: out_ld_en = out_valid = in_dec_ready. There is zero latency from ready to valid, because loader data is combinational from its pointer.
- A beat is transferred only when out_valid=1. On a transfer, beat_cnt increments.
- out_sof = out_valid & (beat_cnt==0). out_eof = out_valid & (beat_cnt==BEATS-1).
- On an eof transfer, beat_cnt returns to 0. Then:
  - if word_idx==WORD_NUM-1 -> DONE;
  - else if GAP_CYCLES>0 -> GAP with gap_cnt=0, and word_idx increments;
  - else stay in STREAM and word_idx increments. The next cycle can carry sof, so back-to-back codewords run with no bubble.
- in_dec_ready low in STREAM: no transfer. Counters hold and the loader pointer holds, keeping the two in lockstep.
- GAP: out_ld_en=0. gap_cnt increments each cycle; when gap_cnt==GAP_CYCLES-1 -> STREAM. in_dec_ready is ignored.
- DONE: out_done=1 and out_ld_en=0. in_start -> CLR, which re-clears the loader for a fresh run. Otherwise DONE holds.
- in_abort has priority over every transition except reset. From CLR, STREAM, GAP or DONE it goes to IDLE next cycle with counters cleared. out_valid is forced 0 in the abort cycle.
- in_start while busy is ignored.
- Reset mid-run: everything returns to reset values immediately. The loader is not cleared until the next CLR.
- The loader's p_word_num must equal out_word_idx after every eof transfer. This is a bench assertion.
- Edge case BEATS==1: every transfer is both sof and eof.

Decomposition:
- Shared package (vector_load_pkg): state encoding constants, clog2 function, zero-check function, BEATS computation, so the loader and sequencer agree.
- Natural sub-module: vector_load_beat_counter. It holds beat_cnt and word_idx with enable, clear and last flags, and is reusable by a future multi-loader arbiter.
- FSM stays in the top.

Test Plan:
1. Nominal run: WORD_LEN=7, P=3, WORD_NUM=2, GAP=0, ready=1; start pulse at cycle 0.
   - Expect ld_Srst at cycle 1; valid at cycles 2-7.
   - Expect sof at cycles 2 and 5; eof at cycles 4 and 7; word_idx 0 then 1.
   - Expect done from cycle 8.
2. Gap insertion: same run with GAP_CYCLES=2.
   - After eof at cycle 4, expect valid=0 at cycles 5-6 and sof at cycle 7.
   - Expect done after eof at cycle 9.
3. Backpressure: ready toggles 1,0,0,1,... during STREAM.
   - Expect valid to mirror ready.
   - Expect beat_cnt and the loader pointer to hold on low cycles; exactly 3 valid beats per codeword; loader data matches the hex file in order.
4. Abort: in_abort during the 2nd beat of word 1.
   - Expect IDLE next cycle, valid=0, busy=0, word_idx=0.
   - A new start re-issues ld_Srst and replays from symbol 0.
5. Async reset mid-GAP: assert in_Arst between clock edges.
   - Expect all outputs 0 without waiting for a clock edge; after release, state is IDLE.
6. Restart from DONE with BEATS==1 (WORD_LEN=4, P=4, WORD_NUM=3).
   - Expect sof=eof on every valid beat and done after 3 transfers.
   - A second start repeats the identical sequence.
